// File: rtl/hcms_pkg.sv
// hcms_pkg: shared FSM states, glyph geometry and ASCII constants for the HCMS display driver
package hcms_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LATCH} state_t;
  localparam int COLS = 5;
  localparam int COL_BITS = 8;
  localparam int GLYPH_W = COLS * COL_BITS;
  localparam int CTRL_W = 8;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7a;
  localparam logic [7:0] ASCII_CASE = 8'h20;
endpackage

// File: rtl/hcms_font_rom.sv
// hcms_font_rom: registered ASCII to 40-bit 5x7 glyph lookup, column 0 in the top byte, bit0 = top row
module hcms_font_rom
  import hcms_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         addr,
  output logic [GLYPH_W-1:0] dout
);
  logic [7:0] uc;
  logic [GLYPH_W-1:0] g;
  always_comb uc = (addr >= ASCII_LC_A && addr <= ASCII_LC_Z) ? addr - ASCII_CASE : addr;
  always_comb begin
    g = '0;
    case (uc)
      8'h20: g = 40'h0000000000;
      8'h21: g = 40'h00005F0000;
      8'h23: g = 40'h147F147F14;
      8'h27: g = 40'h0000070000;
      8'h2E: g = 40'h0060600000;
      8'h30: g = 40'h3E5149453E;
      8'h31: g = 40'h00427F4000;
      8'h32: g = 40'h7249494946;
      8'h33: g = 40'h2141494D33;
      8'h34: g = 40'h1814127F10;
      8'h35: g = 40'h2745454539;
      8'h36: g = 40'h3C4A494931;
      8'h37: g = 40'h4121110907;
      8'h38: g = 40'h3649494936;
      8'h39: g = 40'h464949291E;
      8'h3F: g = 40'h0201590906;
      8'h41: g = 40'h7C1211127C;
      8'h42: g = 40'h7F49494936;
      8'h43: g = 40'h7F41414141;
      8'h44: g = 40'h7F41417F3E;
      8'h45: g = 40'h7F49494941;
      8'h46: g = 40'h7F09090901;
      8'h47: g = 40'h3E4149497A;
      8'h48: g = 40'h7F0808087F;
      8'h49: g = 40'h00417F4100;
      8'h4A: g = 40'h2040413F01;
      8'h4B: g = 40'h7F08142241;
      8'h4C: g = 40'h7F40404040;
      8'h4D: g = 40'h7F021C027F;
      8'h4E: g = 40'h7F0408107F;
      8'h4F: g = 40'h3E4141413E;
      8'h50: g = 40'h7F09090906;
      8'h51: g = 40'h3E4151215E;
      8'h52: g = 40'h7F09192946;
      8'h53: g = 40'h2649494932;
      8'h54: g = 40'h03017F0103;
      8'h55: g = 40'h3F4040403F;
      8'h56: g = 40'h1F2040201F;
      8'h57: g = 40'h3F4038403F;
      8'h58: g = 40'h6314081463;
      8'h59: g = 40'h0304780403;
      8'h5A: g = 40'h6151494543;
      default: g = '0;
    endcase
  end
  always_ff @(posedge clk) dout <= !rstn ? '0 : g;
endmodule

// File: rtl/hcms_frame_streamer.sv
// hcms_frame_streamer: character buffer, font fetch and serial frame/control shifter for an HCMS-290x chain
module hcms_frame_streamer
  import hcms_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int CLK_DIV   = 4,
  parameter int AW        = $clog2(NUM_CHARS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] offset,
  input  logic          refresh,
  input  logic          ctrl_load,
  input  logic [7:0]    ctrl_word,
  output logic          busy,
  output logic          done,
  output logic          disp_din,
  output logic          disp_clk,
  output logic          disp_rs,
  output logic          disp_ce_n
);
  localparam int PER = 2 * CLK_DIV;
  localparam int CW = $clog2(PER);
  localparam int BW = $clog2(GLYPH_W);
  state_t state, state_nx;
  logic [7:0] mem [NUM_CHARS];
  logic [CW-1:0] cnt;
  logic [BW-1:0] bi;
  logic [AW-1:0] pos, off_r, idx;
  logic [GLYPH_W-1:0] gsh, dout;
  logic [CTRL_W-1:0] sw, pw;
  logic is_ctrl, pend_r, pend_c, idle, pe, start_c, start_d, char_end, last_bit;
  always_comb begin
    idle = state == IDLE;
    pe = cnt == CW'(PER - 1);
    start_c = idle && (ctrl_load || pend_c);
    start_d = idle && !start_c && (refresh || pend_r);
    char_end = bi == BW'(GLYPH_W - 1);
    last_bit = is_ctrl ? bi == BW'(CTRL_W - 1) : char_end && pos == '0;
    idx = ((state == SHIFT && char_end) ? pos - 1'b1 : pos) + ((state == SETUP && cnt == '0) ? offset : off_r);
  end
  hcms_font_rom u_rom (
    .clk  (clk),
    .rstn (rstn),
    .addr (mem[idx]),
    .dout (dout)
  );
  always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = (start_c || start_d) ? SETUP : IDLE;
      SETUP: state_nx = pe ? SHIFT : SETUP;
      SHIFT: state_nx = (pe && last_bit) ? LATCH : SHIFT;
      LATCH: state_nx = pe ? IDLE : LATCH;
    endcase
  end
  always_comb begin
    busy = !idle;
    disp_ce_n = idle || state == LATCH;
    disp_rs = !idle && is_ctrl;
    disp_clk = state == SHIFT && cnt >= CW'(CLK_DIV);
    disp_din = state == SHIFT && (is_ctrl ? sw[CTRL_W-1] : gsh[GLYPH_W-1]);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CHARS; i++) mem[i] <= '0;
      cnt <= '0;
      bi <= '0;
      pos <= '0;
      off_r <= '0;
      gsh <= '0;
      sw <= '0;
      pw <= '0;
      is_ctrl <= 1'b0;
      pend_r <= 1'b0;
      pend_c <= 1'b0;
      done <= 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      pend_r <= !start_d && (pend_r || refresh);
      pend_c <= !start_c && (pend_c || ctrl_load);
      if (ctrl_load) pw <= ctrl_word;
      cnt <= (idle || pe) ? '0 : cnt + 1'b1;
      done <= state == LATCH && pe;
      if (start_c || start_d) begin
        is_ctrl <= start_c;
        sw <= ctrl_load ? ctrl_word : pw;
        pos <= AW'(NUM_CHARS - 1);
        bi <= '0;
      end
      if (state == SETUP && cnt == '0) off_r <= offset;
      if (state == SETUP && pe) gsh <= dout;
      if (state == SHIFT && pe) begin
        sw <= sw << 1;
        gsh <= char_end ? dout : gsh << 1;
        pos <= char_end ? pos - 1'b1 : pos;
        bi <= char_end ? '0 : bi + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hcms_frame_streamer.sv
// tb_hcms_frame_streamer: directed table-driven checks of frames, scrolling, control words, pending requests and reset
module tb_hcms_frame_streamer;
  localparam int N = 4;
  localparam int CD = 2;
  localparam int FRAME = 2 * CD * (40 * N + 2);
  localparam int CTRL = 2 * CD * 10;
  typedef struct {
    logic [31:0] chars;
    logic [1:0]  off;
    logic [39:0] first;
    logic [39:0] last;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] offset = '0;
  logic refresh = 1'b0;
  logic ctrl_load = 1'b0;
  logic [7:0] ctrl_word = '0;
  logic busy, done, disp_din, disp_clk, disp_rs, disp_ce_n;
  int pass_n = 0;
  int total_n = 0;
  logic [199:0] cap;
  int ncap;
  vec_t vecs[6];
  always #5 clk = ~clk;
  hcms_frame_streamer #(.NUM_CHARS(N), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .offset    (offset),
    .refresh   (refresh),
    .ctrl_load (ctrl_load),
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .done      (done),
    .disp_din  (disp_din),
    .disp_clk  (disp_clk),
    .disp_rs   (disp_rs),
    .disp_ce_n (disp_ce_n)
  );
  always @(posedge disp_clk) begin
    cap = {cap[198:0], disp_din};
    ncap++;
  end
  function automatic logic [39:0] tg(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      8'h41: return 40'h7C1211127C;
      8'h42: return 40'h7F49494936;
      8'h43: return 40'h7F41414141;
      8'h44: return 40'h7F41417F3E;
      8'h5A: return 40'h6151494543;
      default: return 40'h0;
    endcase
  endfunction
  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic load_buf(input logic [31:0] chars);
    for (int i = 0; i < N; i++) wr(i, chars[8*i +: 8]);
  endtask
  task automatic start_req(input logic r, input logic c, input logic [7:0] w);
    ctrl_word = w;
    refresh = r;
    ctrl_load = c;
    @(negedge clk);
    refresh = 1'b0;
    ctrl_load = 1'b0;
  endtask
  task automatic wait_done(output int blen, output int rsn, output int cen, output logic ok);
    blen = 0;
    rsn = 0;
    cen = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) begin
        blen++;
        if (disp_rs) rsn++;
        if (!disp_ce_n) cen++;
      end
      @(negedge clk);
    end
  endtask
  task automatic clear_cap();
    cap = '0;
    ncap = 0;
  endtask
  initial begin
    int blen, rsn, cen, extra;
    logic ok;
    logic [159:0] exp_full;
    vec_t v;
    vecs[0] = '{32'h44434241, 2'd0, 40'h7F41417F3E, 40'h7C1211127C};
    vecs[1] = '{32'h44434241, 2'd3, 40'h7F41414141, 40'h7F41417F3E};
    vecs[2] = '{32'h44434241, 2'd1, 40'h7C1211127C, 40'h7F49494936};
    vecs[3] = '{32'h64636261, 2'd2, 40'h7F49494936, 40'h7F41414141};
    vecs[4] = '{32'h647E007A, 2'd1, 40'h6151494543, 40'h0};
    vecs[5] = '{32'h647E007A, 2'd3, 40'h0, 40'h7F41417F3E};
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, disp_ce_n, disp_clk, disp_din, disp_rs}, 6'b001000);
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      load_buf(v.chars);
      offset = v.off;
      exp_full = '0;
      for (int p = N - 1; p >= 0; p--) exp_full = {exp_full[119:0], tg(v.chars[8*((p + int'(v.off)) % N) +: 8])};
      clear_cap();
      start_req(1'b1, 1'b0, 8'h00);
      wait_done(blen, rsn, cen, ok);
      check($sformatf("v%0d_done", k), ok, 1'b1);
      check($sformatf("v%0d_busy_len", k), blen, FRAME);
      check($sformatf("v%0d_rs_cycles", k), rsn, 0);
      check($sformatf("v%0d_ce_cycles", k), cen, FRAME - 2 * CD);
      check($sformatf("v%0d_nbits", k), ncap, 40 * N);
      check($sformatf("v%0d_first", k), cap[159:120], v.first);
      check($sformatf("v%0d_last", k), cap[39:0], v.last);
      check($sformatf("v%0d_frame", k), cap[159:0], exp_full);
      check($sformatf("v%0d_busy_at_done", k), busy, 1'b0);
    end
    clear_cap();
    start_req(1'b0, 1'b1, 8'h4F);
    wait_done(blen, rsn, cen, ok);
    check("ctrl_done", ok, 1'b1);
    check("ctrl_busy_len", blen, CTRL);
    check("ctrl_rs_cycles", rsn, CTRL);
    check("ctrl_ce_cycles", cen, CTRL - 2 * CD);
    check("ctrl_nbits", ncap, 8);
    check("ctrl_word", cap[7:0], 8'h4F);
    load_buf(32'h44434241);
    offset = 2'd0;
    clear_cap();
    start_req(1'b1, 1'b1, 8'hA5);
    wait_done(blen, rsn, cen, ok);
    check("both_ctrl_len", blen, CTRL);
    check("both_ctrl_rs", rsn, CTRL);
    @(negedge clk);
    check("both_pend_start", busy, 1'b1);
    wait_done(blen, rsn, cen, ok);
    check("both_dot_done", ok, 1'b1);
    check("both_dot_len", blen, FRAME);
    check("both_dot_rs", rsn, 0);
    check("both_nbits", ncap, 8 + 40 * N);
    check("both_ctrl_bits", cap[167:160], 8'hA5);
    check("both_dot_first", cap[159:120], 40'h7F41417F3E);
    clear_cap();
    start_req(1'b1, 1'b0, 8'h00);
    repeat (100) @(negedge clk);
    start_req(1'b1, 1'b0, 8'h00);
    repeat (100) @(negedge clk);
    start_req(1'b1, 1'b0, 8'h00);
    wait_done(blen, rsn, cen, ok);
    check("merge_first_done", ok, 1'b1);
    @(negedge clk);
    check("merge_pend_start", busy, 1'b1);
    wait_done(blen, rsn, cen, ok);
    check("merge_second_len", blen, FRAME);
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    check("merge_no_third", extra, 0);
    check("merge_nbits", ncap, 80 * N);
    clear_cap();
    start_req(1'b1, 1'b0, 8'h00);
    repeat (50) @(negedge clk);
    wr(0, 8'h5A);
    wait_done(blen, rsn, cen, ok);
    check("wr_busy_done", ok, 1'b1);
    check("wr_busy_first", cap[159:120], 40'h7F41417F3E);
    check("wr_busy_last", cap[39:0], 40'h6151494543);
    start_req(1'b1, 1'b0, 8'h00);
    repeat (100) @(negedge clk);
    start_req(1'b1, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, disp_ce_n, disp_clk, disp_din, disp_rs}, 6'b001000);
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("rst_hold_quiet", extra, 0);
    rstn = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    check("rst_pending_cleared", extra, 0);
    offset = 2'd1;
    clear_cap();
    start_req(1'b1, 1'b0, 8'h00);
    wait_done(blen, rsn, cen, ok);
    check("rst_blank_done", ok, 1'b1);
    check("rst_blank_len", blen, FRAME);
    check("rst_blank_nbits", ncap, 40 * N);
    check("rst_blank_frame", cap[159:0], 160'h0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
